// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive/transmit blocks.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } rx_state_t;

  // Zero-extended data does not change the XOR reduction, so one width serves 5..9 bits.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every brd+1 clk, divisor reloaded at each tick.
module uart_baud_tick #(
  parameter int BRD_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BRD_W-1:0] brd,
  output logic             tick
);

  logic [BRD_W-1:0] cnt;
  logic [BRD_W-1:0] lim;

  // lim holds the divisor in use so a brd change only lands after the current tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      lim  <= '0;
      tick <= 1'b0;
    end else if (cnt == lim) begin
      cnt  <= '0;
      lim  <= brd;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver with mid-bit 3-sample voting, optional parity/2 stop bits,
// and a one-deep valid/ready holding register with sticky overrun.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int BRD_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic [BRD_W-1:0]     brd,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = 4;
  localparam logic [SCW-1:0] SC_V0   = SCW'(OVERSAMPLE/2 - 1);
  localparam logic [SCW-1:0] SC_V1   = SCW'(OVERSAMPLE/2);
  localparam logic [SCW-1:0] SC_V2   = SCW'(OVERSAMPLE/2 + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic                 tick;
  logic                 sync1, rx_s;
  logic [SCW-1:0]       sc;
  logic [BCW-1:0]       bit_cnt;
  logic                 s0, s1, vote;
  logic                 vote_go, wrap, deliver, start_go;
  logic [DATA_BITS-1:0] shreg;
  logic                 pe_int, fe_int;
  logic                 par_en_q, par_odd_q, two_stop_q;

  uart_baud_tick #(.BRD_W(BRD_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .brd   (brd),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  assign vote    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign vote_go = tick && (sc == SC_V2);
  assign wrap    = tick && (sc == SC_LAST);
  assign busy    = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    deliver  = 1'b0;
    start_go = 1'b0;
    case (state_q)
      IDLE: if (tick && !rx_s) begin
        state_d  = START;
        start_go = 1'b1;
      end
      START: begin
        if (vote_go && vote) state_d = IDLE;
        else if (wrap)       state_d = DATA;
      end
      DATA: if (wrap && bit_cnt == BC_LAST) state_d = par_en_q ? PARITY : STOP1;
      PARITY: if (wrap) state_d = STOP1;
      STOP1: begin
        // Deliver at the vote, not the wrap, so a back-to-back start edge is not missed
        if (vote_go && !two_stop_q) begin
          deliver = 1'b1;
          state_d = IDLE;
        end else if (wrap) begin
          state_d = STOP2;
        end
      end
      STOP2: if (vote_go) begin
        deliver = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc         <= '0;
      bit_cnt    <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      shreg      <= '0;
      pe_int     <= 1'b0;
      fe_int     <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      if (state_q == IDLE)  sc <= '0;
      else if (tick)        sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
      if (tick && sc == SC_V0) s0 <= rx_s;
      if (tick && sc == SC_V1) s1 <= rx_s;
      if (start_go) begin
        par_en_q   <= parity_en;
        par_odd_q  <= parity_odd;
        two_stop_q <= two_stop;
        pe_int     <= 1'b0;
        fe_int     <= 1'b0;
        bit_cnt    <= '0;
      end
      if (state_q == DATA && wrap)    bit_cnt <= bit_cnt + 1'b1;
      if (state_q == DATA && vote_go) shreg <= {vote, shreg[DATA_BITS-1:1]};
      if (state_q == PARITY && vote_go)
        pe_int <= (calc_parity(MAX_DATA_BITS'(shreg), par_odd_q) != vote);
      if ((state_q == STOP1 || state_q == STOP2) && vote_go && !vote) fe_int <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (deliver) begin
      if (!valid || ready) begin
        data_out   <= shreg;
        parity_err <= pe_int;
        frame_err  <= fe_int | !vote;   // current stop vote is not yet in fe_int
        valid      <= 1'b1;
        overrun    <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: 8 data bits, 16x oversample, brd=0 (tick every clk).
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [15:0] brd;
  logic       parity_en, parity_odd, two_stop;
  logic [7:0] data_out;
  logic       valid, ready, parity_err, frame_err, overrun, busy;

  int checks   = 0;
  int failures = 0;

  // handshake log and valid-cycle counter, written only by the monitor
  int         hs_cnt = 0;
  int         vcyc   = 0;
  logic [7:0] hs_data [0:31];
  logic       hs_pe   [0:31];
  logic       hs_fe   [0:31];

  always #5 clk = ~clk;

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16), .BRD_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .brd        (brd),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (valid) vcyc <= vcyc + 1;
    if (valid && ready && hs_cnt < 32) begin
      hs_data[hs_cnt] <= data_out;
      hs_pe[hs_cnt]   <= parity_err;
      hs_fe[hs_cnt]   <= frame_err;
      hs_cnt          <= hs_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input bit with_par, input logic par_bit, input logic stop_v);
    hold(1'b0, 16);
    for (int i = 0; i < 8; i++) hold(d[i], 16);
    if (with_par) hold(par_bit, 16);
    hold(stop_v, 16);
    rx_in = 1'b1;
  endtask

  int base;
  int vbase;

  initial begin
    reset = 1'b0; rx_in = 1'b1; brd = 16'd0; ready = 1'b1;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_flags", {parity_err, frame_err}, 2'b00);
    reset = 1'b1;
    hold(1'b1, 10);

    // 1: 8N1 0xA5
    base = hs_cnt; vbase = vcyc;
    send(8'hA5, 0, 1'b0, 1'b1);
    hold(1'b1, 20);
    chk("t1_count", hs_cnt - base, 1);
    chk("t1_vcycles", vcyc - vbase, 1);
    chk("t1_data", hs_data[base], 8'hA5);
    chk("t1_pe", hs_pe[base], 1'b0);
    chk("t1_fe", hs_fe[base], 1'b0);

    // 2: 8E1 0x03 with wrong parity bit 1
    parity_en = 1'b1; parity_odd = 1'b0;
    base = hs_cnt;
    send(8'h03, 1, 1'b1, 1'b1);
    hold(1'b1, 20);
    parity_en = 1'b0;
    chk("t2_count", hs_cnt - base, 1);
    chk("t2_data", hs_data[base], 8'h03);
    chk("t2_pe", hs_pe[base], 1'b1);
    chk("t2_fe", hs_fe[base], 1'b0);

    // 3: bad stop on 0x55, then 0x5A back-to-back
    base = hs_cnt;
    send(8'h55, 0, 1'b0, 1'b0);
    send(8'h5A, 0, 1'b0, 1'b1);
    hold(1'b1, 20);
    chk("t3_count", hs_cnt - base, 2);
    chk("t3_data0", hs_data[base], 8'h55);
    chk("t3_fe0", hs_fe[base], 1'b1);
    chk("t3_data1", hs_data[base+1], 8'h5A);
    chk("t3_fe1", hs_fe[base+1], 1'b0);

    // 4: 6-tick glitch is rejected by the start vote
    base = hs_cnt; vbase = vcyc;
    hold(1'b0, 6);
    chk("t4_busy_during", busy, 1'b1);
    hold(1'b1, 30);
    chk("t4_busy_after", busy, 1'b0);
    chk("t4_no_valid", vcyc - vbase, 0);

    // 5: overrun with ready low
    ready = 1'b0;
    base = hs_cnt;
    send(8'h11, 0, 1'b0, 1'b1);
    send(8'h22, 0, 1'b0, 1'b1);
    hold(1'b1, 10);
    chk("t5_valid", valid, 1'b1);
    chk("t5_data", data_out, 8'h11);
    chk("t5_overrun", overrun, 1'b1);
    ready = 1'b1;
    @(negedge clk);
    chk("t5_valid_clr", valid, 1'b0);
    chk("t5_overrun_clr", overrun, 1'b0);
    chk("t5_hs_data", hs_data[base], 8'h11);

    // 6: reset inside DATA bit 4 with a word pending
    ready = 1'b0;
    hold(1'b1, 10);
    send(8'h7E, 0, 1'b0, 1'b1);
    hold(1'b1, 4);
    chk("t6_pending", valid, 1'b1);
    hold(1'b0, 16);
    hold(1'b1, 16); hold(1'b0, 16); hold(1'b0, 16); hold(1'b1, 16);
    hold(1'b1, 8);
    chk("t6_busy_pre", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("t6_valid", valid, 1'b0);
    chk("t6_data", data_out, 8'h00);
    chk("t6_busy", busy, 1'b0);
    chk("t6_overrun", overrun, 1'b0);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1; ready = 1'b1;
    base = hs_cnt;
    hold(1'b1, 10);
    send(8'h3C, 0, 1'b0, 1'b1);
    hold(1'b1, 20);
    chk("t6_count", hs_cnt - base, 1);
    chk("t6_rx_data", hs_data[base], 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
